// File: rtl/ssd1306_spi_rx_if.sv
// Register-window and pin bundle between the TinyQV core side and ssd1306_spi_rx.
// The core side (master) drives pins and register strobes; the receiver (slave) answers.
interface ssd1306_spi_rx_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output ui_in,
    output address,
    output data_write,
    output data_in,
    input  uo_out,
    input  data_out
  );

  modport slave (
    input  ui_in,
    input  address,
    input  data_write,
    input  data_in,
    output uo_out,
    output data_out
  );
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SPI mode-0 receiver that captures the SSD1306 byte stream into a {dc,byte} FIFO.
// Define SSD1306_RX_DECODE_EN to include the PAGE/COLUMN shadow decoder.
module ssd1306_spi_rx #(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  ssd1306_spi_rx_if.slave bus
);

  localparam int         AW      = (DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_HEAD   = 4'd1;
  localparam logic [3:0] ADDR_DC     = 4'd2;
  localparam logic [3:0] ADDR_PAGE   = 4'd3;
  localparam logic [3:0] ADDR_COLUMN = 4'd4;
  localparam logic [3:0] ADDR_DCLR   = 4'd5;

  logic          sck_s;
  logic          mosi_s;
  logic          cs_n_s;
  logic          dc_s;
  logic          sck_prev_r;
  logic          cs_prev_r;
  logic          sck_rise_s;
  logic          cs_rise_s;
  logic          shift_en_s;
  logic          frame_set_s;
  logic          armed_r;
  logic [2:0]    bit_cnt_r;
  logic [6:0]    shift_r;
  logic          byte_valid_r;
  logic [7:0]    byte_r;
  logic          byte_dc_r;
  logic [8:0]    mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [2:0]    level_r;
  logic [2:0]    level_next_s;
  logic          ovf_r;
  logic          frame_err_r;
  logic          pop_req_s;
  logic          clr_req_s;
  logic          do_push_s;
  logic          do_pop_s;
  logic          ovf_set_s;
  logic          full_s;
  logic          not_empty_s;
  logic [8:0]    head_s;
  logic [7:0]    page_rd_s;
  logic [7:0]    column_rd_s;
  logic [7:0]    rd_data_s;
  logic          unused_bits_s;

  assign sck_s         = bus.ui_in[1];
  assign mosi_s        = bus.ui_in[2];
  assign cs_n_s        = bus.ui_in[3];
  assign dc_s          = bus.ui_in[4];
  assign unused_bits_s = ^{bus.ui_in[7:5], bus.ui_in[0], bus.data_in[7:2]};

  assign sck_rise_s  = sck_s & ~sck_prev_r;
  assign cs_rise_s   = cs_n_s & ~cs_prev_r;
  assign shift_en_s  = sck_rise_s & ~cs_n_s & armed_r;
  assign frame_set_s = cs_rise_s & (bit_cnt_r != 3'd0);

  assign pop_req_s   = bus.data_write & (bus.address == ADDR_STATUS) & bus.data_in[0];
  assign clr_req_s   = bus.data_write & (bus.address == ADDR_STATUS) & bus.data_in[1];
  assign full_s      = (level_r == DEPTH_L);
  assign not_empty_s = (level_r != 3'd0);
  assign head_s      = mem_r[rd_ptr_r];

  // One-deep history of SCK and CS_n for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev_r <= 1'b0;
      cs_prev_r  <= 1'b0;
    end else begin
      sck_prev_r <= sck_s;
      cs_prev_r  <= cs_n_s;
    end
  end

  // Shift register, bit counter and the registered completed-byte strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r      <= 1'b0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 7'd0;
      byte_valid_r <= 1'b0;
      byte_r       <= 8'h00;
      byte_dc_r    <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      if (cs_n_s) begin
        armed_r <= 1'b1;
      end
      if (frame_set_s) begin
        bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
        shift_r   <= {shift_r[5:0], mosi_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_valid_r <= 1'b1;
          byte_r       <= {shift_r, mosi_s};
          byte_dc_r    <= dc_s;
        end
      end
    end
  end

  // Push/pop arbitration: a pop frees the slot a simultaneous push needs, an empty pop is void
  always_comb begin
    do_push_s = 1'b0;
    ovf_set_s = 1'b0;
    do_pop_s  = 1'b0;
    if (byte_valid_r) begin
      if (!full_s || pop_req_s) begin
        do_push_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else begin
      do_push_s = 1'b0;
    end
    if (pop_req_s && not_empty_s) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
  end

  // Next FIFO occupancy
  always_comb begin
    level_next_s = level_r;
    case ({do_push_s, do_pop_s})
      2'b10:   level_next_s = level_r + 3'd1;
      2'b01:   level_next_s = level_r - 3'd1;
      default: level_next_s = level_r;
    endcase
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 9'd0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      level_r  <= 3'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= {byte_dc_r, byte_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      level_r <= level_next_s;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r       <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (clr_req_s) begin
        ovf_r <= 1'b0;
      end
      if (frame_set_s) begin
        frame_err_r <= 1'b1;
      end else if (clr_req_s) begin
        frame_err_r <= 1'b0;
      end
    end
  end

`ifdef SSD1306_RX_DECODE_EN
  logic [2:0] page_r;
  logic [6:0] column_r;
  logic       addr_clr_s;

  assign addr_clr_s = bus.data_write & (bus.address == ADDR_DCLR);

  // Shadow page/column tracker; sees dropped bytes too since it follows the wire
  always_ff @(posedge clk) begin
    if (rst) begin
      page_r   <= 3'd0;
      column_r <= 7'd0;
    end else if (addr_clr_s) begin
      page_r   <= 3'd0;
      column_r <= 7'd0;
    end else if (byte_valid_r) begin
      if (byte_dc_r) begin
        column_r <= column_r + 7'd1;
      end else if (byte_r[7:3] == 5'b10110) begin
        page_r <= byte_r[2:0];
      end else if (byte_r[7:4] == 4'h0) begin
        column_r[3:0] <= byte_r[3:0];
      end else if (byte_r[7:3] == 5'b00010) begin
        column_r[6:4] <= byte_r[2:0];
      end
    end
  end

  assign page_rd_s   = {5'b00000, page_r};
  assign column_rd_s = {1'b0, column_r};
`else
  assign page_rd_s   = 8'h00;
  assign column_rd_s = 8'h00;
`endif

  // Register read mux
  always_comb begin
    rd_data_s = 8'h00;
    case (bus.address)
      ADDR_STATUS: rd_data_s = {1'b0, level_r, frame_err_r, ovf_r, full_s, not_empty_s};
      ADDR_HEAD:   rd_data_s = not_empty_s ? head_s[7:0] : 8'h00;
      ADDR_DC:     rd_data_s = not_empty_s ? {1'b1, 6'b000000, head_s[8]} : 8'h00;
      ADDR_PAGE:   rd_data_s = page_rd_s;
      ADDR_COLUMN: rd_data_s = column_rd_s;
      default:     rd_data_s = 8'h00;
    endcase
  end

  assign bus.data_out = rd_data_s;
  assign bus.uo_out   = {2'b00, not_empty_s, 5'b00000};

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Randomized scoreboard bench for ssd1306_spi_rx: a queue-based model of the
// FIFO, flags and page/column tracker predicts every register read.
`timescale 1ns/1ps
module tb_ssd1306_spi_rx;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic dc = 1'b0;
  bit   rd_strobe = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  bit m_ovf;
  bit m_ferr;
  int m_page;
  int m_col;

  ssd1306_spi_rx_if bus();
  ssd1306_spi_rx #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.ui_in = {3'b000, dc, cs_n, mosi, sck, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    int lvl = exp_q.size();
    return {1'b0, 3'(lvl), m_ferr, m_ovf, (lvl == DEPTH), (lvl != 0)};
  endfunction

  function automatic logic [7:0] exp_page();
`ifdef SSD1306_RX_DECODE_EN
    return 8'(m_page);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] exp_col();
`ifdef SSD1306_RX_DECODE_EN
    return 8'(m_col);
`else
    return 8'h00;
`endif
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    m_page = 0;
    m_col = 0;
  endfunction

  function automatic void model_decode(input logic [7:0] b, input logic dcv);
    if (dcv) m_col = (m_col + 1) % 128;
    else if (b >= 8'hB0 && b <= 8'hB7) m_page = b - 8'hB0;
    else if (b <= 8'h0F) m_col = (m_col / 16) * 16 + b;
    else if (b >= 8'h10 && b <= 8'h17) m_col = (b - 8'h10) * 16 + (m_col % 16);
  endfunction

  // Scoreboard monitor: every strobed head read is compared with the oldest expected entry
  always @(negedge clk) begin
    if (rd_strobe && (bus.address == 4'd1 || bus.address == 4'd2)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL head_underflow actual=%02h required=no_entry", bus.data_out);
      end else if (bus.address == 4'd1) begin
        if (bus.data_out !== exp_q[0][7:0]) begin
          errors++;
          $display("FAIL head_data actual=%02h required=%02h", bus.data_out, exp_q[0][7:0]);
        end
      end else begin
        if (bus.data_out !== {1'b1, 6'b000000, exp_q[0][8]}) begin
          errors++;
          $display("FAIL head_dc actual=%02h required=%02h", bus.data_out, {1'b1, 6'b000000, exp_q[0][8]});
        end
        exp_q.delete(0);
      end
    end
  end

  task automatic check_reg(input logic [3:0] addr, input logic [7:0] exp, input string name);
    tick();
    bus.address = addr;
    @(negedge clk);
    check(name, bus.data_out, exp);
  endtask

  task automatic check_status(input string name);
    logic [7:0] st;
    st = exp_status();
    check_reg(4'd0, st, name);
    check({name, "_irq"}, bus.uo_out, {2'b00, st[0], 5'b00000});
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [7:0] val);
    tick();
    bus.address = addr;
    bus.data_in = val;
    bus.data_write = 1'b1;
    tick();
    bus.data_write = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic pop_entry();
    tick();
    rd_strobe = 1'b1;
    bus.address = 4'd1;
    tick();
    bus.address = 4'd2;
    tick();
    rd_strobe = 1'b0;
    bus.address = 4'd0;
    bus.data_in = 8'h01;
    bus.data_write = 1'b1;
    tick();
    bus.data_write = 1'b0;
    bus.data_in = 8'h00;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_entry();
  endtask

  task automatic clear_flags();
    write_reg(4'd0, 8'h02);
    m_ovf = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Wire-level SPI: each phase lasts h clocks; optional pop lands on the push cycle of the last bit
  task automatic spi_bits(input logic [7:0] b, input logic dcv, input int n, input int h, input bit pop_last);
    for (int i = 0; i < n; i++) begin
      tick();
      sck = 1'b0;
      mosi = b[7-i];
      dc = dcv;
      repeat (h - 1) tick();
      tick();
      sck = 1'b1;
      if (pop_last && i == n - 1) begin
        tick();
        bus.address = 4'd0;
        bus.data_in = 8'h01;
        bus.data_write = 1'b1;
        tick();
        bus.data_write = 1'b0;
        bus.data_in = 8'h00;
        repeat ((h > 3) ? h - 3 : 0) tick();
      end else begin
        repeat (h - 1) tick();
      end
    end
    tick();
    sck = 1'b0;
    repeat (h) tick();
  endtask

  task automatic cs_set(input logic v);
    tick();
    cs_n = v;
    repeat (2) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv, input bit pop_last);
    spi_bits(b, dcv, 8, int'($urandom_range(2, 4)), pop_last);
    if (pop_last && exp_q.size() > 0) exp_q.delete(0);
    if (exp_q.size() < DEPTH) exp_q.push_back({dcv, b});
    else m_ovf = 1'b1;
    model_decode(b, dcv);
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    spi_bits(b, 1'b0, n, int'($urandom_range(2, 4)), 1'b0);
    cs_set(1'b1);
    m_ferr = 1'b1;
    cs_set(1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address = 4'd0;
    bus.data_write = 1'b0;
    bus.data_in = 8'h00;
    repeat (4) tick();
    rst = 1'b0;
    model_reset();

    for (int a = 0; a < 8; a++) check_reg(4'(a), 8'h00, "reset_reg");
    check("reset_uo_out", bus.uo_out, 8'h00);

    // Single byte with D/C=1
    cs_set(1'b1);
    cs_set(1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    check_reg(4'd0, 8'h11, "t1_status_const");
    check_status("t1_status");
    pop_entry();
    check_status("t1_after_pop");
    check_reg(4'd1, 8'h00, "empty_head_data");
    check_reg(4'd2, 8'h00, "empty_head_dc");

    // Overflow on the fifth byte
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
    check_reg(4'd0, 8'h47, "t2_status_const");
    check_status("t2_status");
    drain();
    clear_flags();
    check_status("t2_cleared");

    // Partial frame then a clean byte
    send_partial(8'hE0, 3);
    check_status("t3_frame_err");
    send_byte(8'h3C, 1'b0, 1'b0);
    check_status("t3_after_byte");
    drain();
    clear_flags();

    // Page/column tracking
    write_reg(4'd5, 8'h5A);
    m_page = 0;
    m_col = 0;
    send_byte(8'hB3, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'h17, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    check_reg(4'd3, exp_page(), "t4_page");
    check_reg(4'd4, exp_col(), "t4_column");
    send_byte(8'($urandom), 1'b1, 1'b0);
    check_reg(4'd4, exp_col(), "t4_column_wrap");
    check_status("t4_status");
    write_reg(4'd5, 8'h00);
    m_page = 0;
    m_col = 0;
    check_reg(4'd3, 8'h00, "t4_page_clr");
    check_reg(4'd4, 8'h00, "t4_col_clr");
    drain();
    clear_flags();

    // Push and pop in the same cycle: full, then empty
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'($urandom), 1'b0);
    send_byte(8'hC7, 1'b1, 1'b1);
    check_status("t5_full_pushpop");
    drain();
    send_byte(8'h6E, 1'b0, 1'b1);
    check_status("t5_empty_pushpop");
    drain();

    // Reset in the middle of a transfer
    spi_bits(8'hF0, 1'b0, 4, 3, 1'b0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    spi_bits(8'h0F, 1'b0, 4, 3, 1'b0);
    spi_bits(8'hFF, 1'b1, 8, 3, 1'b0);
    check_status("t6_after_reset");
    cs_set(1'b1);
    cs_set(1'b0);
    send_byte(8'h81, 1'b0, 1'b0);
    check_status("t6_rearmed");
    drain();

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) send_byte(8'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0));
      else if (r < 8) begin
        if (exp_q.size() > 0) pop_entry();
      end
      else if (r == 8) send_partial(8'($urandom), int'($urandom_range(1, 7)));
      else clear_flags();
      check_status("rnd_status");
      check_reg(4'd3, exp_page(), "rnd_page");
      check_reg(4'd4, exp_col(), "rnd_column");
    end
    drain();
    check_status("final_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
